// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types, opcode constants and helpers for the register
//               file with scoreboard.                              Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  // Opcodes whose instructions carry no writeback result
  localparam logic [3:0] OP_NOWB_A = 4'b1011;
  localparam logic [3:0] OP_NOWB_B = 4'b1110;
  localparam logic [3:0] OP_NOWB_C = 4'b1111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  function automatic logic is_wb_opcode(input logic [3:0] opcode);
    return !((opcode == OP_NOWB_A) || (opcode == OP_NOWB_B) || (opcode == OP_NOWB_C));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// rf_read_port : one combinational read port -- zero register, write bypass,
//                then array contents.                              Rev 1.0
// ============================================================================
`default_nettype none

module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wq,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_pend,
  output logic [DATA_W-1:0] rd_data,
  output logic              pend
);

  always_comb begin
    rd_data = arr_data;
    pend    = arr_pend;
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
      pend    = 1'b0;
    end else if ((BYPASS != 0) && wq && (wr_addr == rd_addr)) begin
      // A writing producer always clears the scoreboard bit for the reader
      rd_data = wr_data;
      pend    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : DEPTH x DATA_W register file with pending bits, write
//                      bypass and a sequenced clear sweep.         Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              pend1,
  output logic              pend2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  clr_state_e        state;
  clr_state_e        state_next;
  logic [ADDR_W-1:0] idx;
  logic              idle;
  logic              wq;
  logic              rq;

  assign idle     = (state == IDLE);
  assign clr_busy = (state == SWEEP);
  assign wq = wr_en && is_wb_opcode(opcode) && idle &&
              !((ZERO_REG != 0) && (wr_addr == '0));
  assign rq = rsv_en && idle && !((ZERO_REG != 0) && (rsv_addr == '0));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = SWEEP;
      SWEEP:   if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // idx is held at 0 while idle so a sweep always starts at register 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (state == SWEEP) idx <= idx + 1'b1;
      else                idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else if (state == SWEEP) begin
      regs[idx]    <= '0;
      pending[idx] <= 1'b0;
    end else begin
      if (wq) begin
        regs[wr_addr]    <= wr_data;
        pending[wr_addr] <= 1'b0;
      end
      // Later assignment wins: a new reservation outranks the retiring write
      if (rq) pending[rsv_addr] <= 1'b1;
    end
  end

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port1 (
    .rd_addr (rd_addr1),
    .wq      (wq),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .arr_data(regs[rd_addr1]),
    .arr_pend(pending[rd_addr1]),
    .rd_data (rd_data1),
    .pend    (pend1)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port2 (
    .rd_addr (rd_addr2),
    .wq      (wq),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .arr_data(regs[rd_addr2]),
    .arr_pend(pending[rd_addr2]),
    .rd_data (rd_data2),
    .pend    (pend2)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed table, clear/reset sequences and random
//                         traffic against a behavioural model.    Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        pend1, pend2;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        clr_req;
  logic        clr_busy;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .pend1(pend1), .pend2(pend2), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  // Behavioural model: plain arrays plus a "sweep cycles remaining" view
  logic [31:0] m_regs [16];
  bit          m_pend [16];
  bit          m_busy;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic rst_n; logic [3:0] op; logic wr_en; logic [3:0] wa; logic [31:0] wd;
    logic [3:0] a1; logic [3:0] a2; logic rsv_en; logic [3:0] ra; logic clr;
    logic [31:0] d1; logic p1; logic [31:0] d2; logic p2; logic busy;
  } vec_t;
  vec_t tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit write_ok();
    return wr_en && !(opcode inside {4'hB, 4'hE, 4'hF}) && !m_busy && (wr_addr != 4'd0);
  endfunction

  function automatic void exp_read(input logic [3:0] a, output logic [31:0] d, output logic p);
    if (a == 4'd0) begin
      d = 32'h0; p = 1'b0;
    end else if (write_ok() && wr_addr == a) begin
      d = wr_data; p = 1'b0;
    end else begin
      d = m_regs[a]; p = m_pend[a];
    end
  endfunction

  task automatic model_edge();
    bit wok;
    wok = write_ok();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
      m_busy = 1'b0; m_cnt = 0;
    end else if (m_busy) begin
      m_regs[m_cnt] = 32'h0; m_pend[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == 16) begin m_busy = 1'b0; m_cnt = 0; end
    end else begin
      if (wok) begin m_regs[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0; end
      if (rsv_en && rsv_addr != 4'd0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin m_busy = 1'b1; m_cnt = 0; end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    logic [31:0] d1, d2;
    logic p1, p2;
    #4;
    exp_read(rd_addr1, d1, p1);
    exp_read(rd_addr2, d2, p2);
    chk("rd_data1", rd_data1, d1);
    chk1("pend1", pend1, p1);
    chk("rd_data2", rd_data2, d2);
    chk1("pend2", pend2, p2);
    chk1("clr_busy", clr_busy, m_busy);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; opcode = 4'h1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
    rsv_en = 1'b0; rsv_addr = 4'd0; clr_req = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      idle_inputs();
      rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a);
      #4;
      chk({tag, "_d1"}, rd_data1, 32'h0);
      chk1({tag, "_p1"}, pend1, 1'b0);
      chk({tag, "_d2"}, rd_data2, 32'h0);
      chk1({tag, "_busy"}, clr_busy, 1'b0);
      edge_step();
    end
  endtask

  initial begin
    int busy_cnt;
    idle_inputs();
    rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
    m_busy = 1'b0; m_cnt = 0;

    rst_n = 1'b0;
    edge_step();
    edge_step();
    read_all_zero("reset");

    // rst, op, wen, wa, wd, a1, a2, rsv, ra, clr | d1, p1, d2, p2, busy
    tab[0]  = '{1'b1,4'h1,1'b1,4'd5,32'hDEADBEEF,4'd5,4'd5,1'b0,4'd0,1'b0, 32'hDEADBEEF,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[1]  = '{1'b1,4'h1,1'b0,4'd5,32'h0,4'd5,4'd0,1'b0,4'd0,1'b0, 32'hDEADBEEF,1'b0,32'h0,1'b0,1'b0};
    tab[2]  = '{1'b1,4'hB,1'b1,4'd7,32'h11111111,4'd7,4'd5,1'b0,4'd0,1'b0, 32'h0,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[3]  = '{1'b1,4'hE,1'b1,4'd7,32'h22222222,4'd7,4'd5,1'b0,4'd0,1'b0, 32'h0,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[4]  = '{1'b1,4'hF,1'b1,4'd7,32'h33333333,4'd7,4'd5,1'b0,4'd0,1'b0, 32'h0,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[5]  = '{1'b1,4'h1,1'b0,4'd7,32'h0,4'd7,4'd5,1'b0,4'd0,1'b0, 32'h0,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[6]  = '{1'b1,4'h0,1'b1,4'd7,32'h77,4'd7,4'd5,1'b0,4'd0,1'b0, 32'h77,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[7]  = '{1'b1,4'h1,1'b0,4'd0,32'h0,4'd7,4'd3,1'b0,4'd0,1'b0, 32'h77,1'b0,32'h0,1'b0,1'b0};
    tab[8]  = '{1'b1,4'h1,1'b0,4'd0,32'h0,4'd3,4'd7,1'b1,4'd3,1'b0, 32'h0,1'b0,32'h77,1'b0,1'b0};
    tab[9]  = '{1'b1,4'h1,1'b0,4'd0,32'h0,4'd3,4'd3,1'b0,4'd0,1'b0, 32'h0,1'b1,32'h0,1'b1,1'b0};
    tab[10] = '{1'b1,4'h1,1'b1,4'd3,32'h12,4'd3,4'd5,1'b0,4'd0,1'b0, 32'h12,1'b0,32'hDEADBEEF,1'b0,1'b0};
    tab[11] = '{1'b1,4'h1,1'b0,4'd0,32'h0,4'd3,4'd3,1'b0,4'd0,1'b0, 32'h12,1'b0,32'h12,1'b0,1'b0};
    tab[12] = '{1'b1,4'h1,1'b1,4'd3,32'h12,4'd3,4'd7,1'b1,4'd3,1'b0, 32'h12,1'b0,32'h77,1'b0,1'b0};
    tab[13] = '{1'b1,4'h1,1'b0,4'd0,32'h0,4'd3,4'd3,1'b0,4'd0,1'b0, 32'h12,1'b1,32'h12,1'b1,1'b0};
    tab[14] = '{1'b1,4'h1,1'b1,4'd0,32'hFFFF,4'd0,4'd0,1'b1,4'd0,1'b0, 32'h0,1'b0,32'h0,1'b0,1'b0};
    tab[15] = '{1'b1,4'h1,1'b0,4'd0,32'h0,4'd0,4'd3,1'b0,4'd0,1'b0, 32'h0,1'b0,32'h12,1'b1,1'b0};

    for (int i = 0; i < 16; i++) begin
      rst_n = tab[i].rst_n; opcode = tab[i].op; wr_en = tab[i].wr_en;
      wr_addr = tab[i].wa; wr_data = tab[i].wd; rd_addr1 = tab[i].a1;
      rd_addr2 = tab[i].a2; rsv_en = tab[i].rsv_en; rsv_addr = tab[i].ra;
      clr_req = tab[i].clr;
      #4;
      chk($sformatf("tab%0d_d1", i), rd_data1, tab[i].d1);
      chk1($sformatf("tab%0d_p1", i), pend1, tab[i].p1);
      chk($sformatf("tab%0d_d2", i), rd_data2, tab[i].d2);
      chk1($sformatf("tab%0d_p2", i), pend2, tab[i].p2);
      chk1($sformatf("tab%0d_busy", i), clr_busy, tab[i].busy);
      edge_step();
    end

    // Fill every register, then sweep with a dropped write and a repeated clr_req
    for (int a = 0; a < 16; a++) begin
      idle_inputs();
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = $urandom | 32'h1;
      rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a);
      check_model();
      edge_step();
    end
    idle_inputs();
    clr_req = 1'b1;
    check_model();
    edge_step();
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      rd_addr1 = 4'(c % 16); rd_addr2 = 4'd2;
      if (c == 5) begin wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hABCD; end
      if (c == 7) begin clr_req = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd1; end
      check_model();
      if (!clr_busy) break;
      busy_cnt++;
      edge_step();
    end
    chk("sweep_len", 32'(busy_cnt), 32'd16);
    read_all_zero("swept");
    idle_inputs();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h44; rd_addr1 = 4'd4; rd_addr2 = 4'd4;
    check_model();
    edge_step();
    idle_inputs();
    check_model();

    // Reset in the middle of a sweep
    for (int a = 10; a < 16; a++) begin
      idle_inputs();
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 32'hA000 + 32'(a);
      rd_addr1 = 4'(a); rd_addr2 = 4'd4;
      check_model();
      edge_step();
    end
    idle_inputs();
    clr_req = 1'b1;
    check_model();
    edge_step();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      rd_addr1 = 4'd15; rd_addr2 = 4'd10;
      check_model();
      edge_step();
    end
    idle_inputs();
    rst_n = 1'b0;
    edge_step();
    idle_inputs();
    #4;
    chk1("rst_abort_busy", clr_busy, 1'b0);
    edge_step();
    read_all_zero("rst_abort");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      opcode   = 4'($urandom_range(0, 15));
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = $urandom;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addr2 = 4'($urandom_range(0, 15));
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 4'($urandom_range(0, 15));
      clr_req  = ($urandom_range(0, 49) == 0);
      check_model();
      edge_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised, clocked successor to the combinational register bank: a DEPTH x DATA_W register file with one write port, two asynchronous read ports, write-to-read bypass, opcode-based write suppression, a per-register pending (scoreboard) bit for pipelined issue, and a sequenced clear engine. It sits between decode (read addresses, reservations) and writeback (write port) in the pipelined datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes and reservations
- BYPASS, 1, when 1, a same-cycle qualifying write forwards to matching read ports
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- opcode  in  4  opcode of the instruction at writeback; gates writes
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write destination
- wr_data  in  DATA_W  write data
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data (combinational)
- pend1, pend2  out  1  pending bit of rd_addr1 / rd_addr2 after bypass
- rsv_en  in  1  reserve request: mark rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- clr_req  in  1  one-cycle pulse: start clear sweep
- clr_busy  out  1  clear sweep in progress

## Operation
- Qualifying write (wq): wr_en=1 AND opcode not in {4'b1011, 4'b1110, 4'b1111} AND state=IDLE AND NOT (ZERO_REG AND wr_addr=0).
- wq: regs[wr_addr] <= wr_data; pending[wr_addr] <= 0.
- Reservation (rq): rsv_en=1 AND state=IDLE AND NOT (ZERO_REG AND rsv_addr=0): pending[rsv_addr] <= 1.
- wq and rq to same address in same cycle: data written, pending ends 1 (new producer wins).
- Read port n: if ZERO_REG and rd_addrN=0 -> data 0, pend 0; else if BYPASS and wq and wr_addr=rd_addrN -> data=wr_data, pend=0; else data=regs[rd_addrN], pend=pending[rd_addrN].
- Both read ports may address the same register; no conflict.
- Clear FSM states IDLE, SWEEP.
  - IDLE -> SWEEP on clr_req=1; idx <= 0.
  - SWEEP: each cycle regs[idx] <= 0, pending[idx] <= 0, idx <= idx+1; after idx=DEPTH-1 -> IDLE.
  - clr_req while SWEEP ignored. wr_en/rsv_en ignored during SWEEP (not queued).
  - Reads during SWEEP return current array contents (swept entries already 0); no bypass.
- Reset (rst_n=0 at edge): all regs 0, all pending 0, state IDLE, idx 0. Reset mid-sweep aborts sweep.

## Timing
- Write/reservation visible in array one edge after request; visible same cycle on read ports via bypass (data only; reservation is not bypassed).
- Read latency: 0 cycles (combinational from addresses).
- clr_busy = (state=SWEEP); rises the cycle after clr_req is sampled, stays high exactly DEPTH cycles, first write accepted on the cycle clr_busy is low again.
- Reset values: rd_data1/2 = 0, pend1/2 = 0, clr_busy = 0.
- idx is ADDR_W bits; wrap from DEPTH-1 to 0 coincides with return to IDLE.

## Structure
- Package regfile_pkg: no-writeback opcode constants (4'b1011, 4'b1110, 4'b1111), state enum {IDLE, SWEEP}, function is_wb_opcode(opcode).
- Sub-module rf_read_port (zero-reg / bypass / array select for one port), instantiated twice.
- Array, pending vector, FSM and idx counter in top module.

## Test plan
- Reset, then read all 16 addresses -> every rd_data=0, pend=0, clr_busy=0.
- Write 32'hDEADBEEF to r5 with opcode 4'b0001; same cycle rd_addr1=5 -> rd_data1=32'hDEADBEEF (bypass); next cycle still DEADBEEF with no write.
- Write r7 with opcode 4'b1011, 4'b1110, 4'b1111 -> r7 unchanged (0); opcode 4'b0000 -> written.
- rsv_en r3 -> pend=1 next cycle; write r3=32'h12 -> pend1=0 same cycle via bypass, 0 after edge; simultaneous rsv+write r3 -> data 32'h12, pend=1.
- Fill all regs, pulse clr_req -> clr_busy high 16 cycles, write during sweep dropped, all regs 0 after; clr_req during sweep does not extend it.
- ZERO_REG=1: write 32'hFFFF to r0 and reserve r0 -> reads 0, pend 0; rst_n low at sweep cycle 6 -> clr_busy 0 next cycle, all regs 0.
